scard_rx_ctrl: RTL and testbench



---
 rtl/scard_rx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_scard_rx_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scard_rx_ctrl.sv
// Smartcard receive controller: packet tagging, FWFT FIFO, waiting-time watchdog, sticky errors.
// Define SCARD_RX_TIMEOUT_EN to build the watchdog; otherwise timeout is tied low.
module scard_rx_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned TIMEOUT_W  = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 rx_data_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_endofpacket,
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
    input  logic                 clear_errors,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DEPTH_LOG2:0]  fifo_level,
    output logic [7:0]           pkt_bytes,
    output logic                 overflow,
    output logic                 timeout,
    output logic                 busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned CW    = DEPTH_LOG2 + 2;

    typedef enum logic [1:0] {StOff, StWait, StRecv} state_e;

    state_e                state_q, state_d;
    logic [7:0]            stage_data_q, stage_data_d;
    logic                  stage_vld_q, stage_vld_d;
    logic [7:0]            pkt_q, pkt_d;
    logic                  overflow_q;
    logic [8:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, rptr_q, wptr1;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [CW-1:0]         cap;
    logic                  push0, push1, acc0, acc1, pop, drop, expire;
    logic [8:0]            push0_entry, push1_entry;

    assign out_valid           = (level_q != '0);
    assign pop                 = out_valid && out_ready;
    assign {out_last, out_data} = mem_q[rptr_q];
    assign fifo_level          = level_q;
    assign pkt_bytes           = pkt_q;
    assign overflow            = overflow_q;

`ifdef SCARD_RX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_q;
    logic                 timeout_q;

    // A byte arriving in the expiry cycle wins, so rx_data_ready masks expiry.
    assign expire = (state_q != StOff) && enable && !rx_data_ready &&
                    (timeout_cycles != '0) && (wd_q == timeout_cycles);
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if ((state_q == StOff) || !enable || rx_data_ready || expire) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + TIMEOUT_W'(1);
            end
            timeout_q <= expire | (timeout_q & ~clear_errors);
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^timeout_cycles;
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StOff;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff:   if (enable) state_d = StWait;
            StWait: begin
                if (!enable) state_d = StOff;
                else if (rx_data_ready && !rx_endofpacket) state_d = StRecv;
            end
            StRecv: begin
                if (!enable) state_d = StOff;
                else if (rx_endofpacket || expire) state_d = StWait;
            end
            default: state_d = StOff;
        endcase
    end

    // Staging and push requests; push1 is only the same-cycle byte+end-of-packet case.
    always_comb begin
        push0        = 1'b0;
        push1        = 1'b0;
        push0_entry  = {1'b0, stage_data_q};
        push1_entry  = {1'b1, rx_data};
        stage_data_d = stage_data_q;
        stage_vld_d  = stage_vld_q;
        pkt_d        = pkt_q;
        busy         = (state_q == StRecv);
        unique case (state_q)
            StWait: begin
                if (enable && rx_data_ready) begin
                    pkt_d = 8'd1;
                    if (rx_endofpacket) begin
                        push0       = 1'b1;
                        push0_entry = {1'b1, rx_data};
                    end else begin
                        stage_data_d = rx_data;
                        stage_vld_d  = 1'b1;
                    end
                end
            end
            StRecv: begin
                if (!enable) begin
                    push0       = stage_vld_q;
                    push0_entry = {1'b1, stage_data_q};
                    stage_vld_d = 1'b0;
                end else if (rx_data_ready) begin
                    push0 = stage_vld_q;
                    if (pkt_q != 8'hFF) pkt_d = pkt_q + 8'd1;
                    if (rx_endofpacket) begin
                        push1       = 1'b1;
                        stage_vld_d = 1'b0;
                    end else begin
                        stage_data_d = rx_data;
                    end
                end else if (rx_endofpacket || expire) begin
                    push0       = stage_vld_q;
                    push0_entry = {1'b1, stage_data_q};
                    stage_vld_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Free slots this cycle, counting a simultaneous pop.
    always_comb begin
        cap     = CW'(DEPTH) - CW'(level_q) + CW'(pop);
        acc0    = push0 && (cap >= CW'(1));
        acc1    = push1 && (cap >= (acc0 ? CW'(2) : CW'(1)));
        drop    = (push0 && !acc0) || (push1 && !acc1);
        wptr1   = acc0 ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
        level_d = level_q + LW'(acc0) + LW'(acc1) - LW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q        <= '{default: '0};
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            stage_data_q <= '0;
            stage_vld_q  <= 1'b0;
            pkt_q        <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (acc0) mem_q[wptr_q] <= push0_entry;
            if (acc1) mem_q[wptr1] <= push1_entry;
            wptr_q       <= acc1 ? wptr1 + DEPTH_LOG2'(1) : wptr1;
            if (pop) rptr_q <= rptr_q + DEPTH_LOG2'(1);
            level_q      <= level_d;
            stage_data_q <= stage_data_d;
            stage_vld_q  <= stage_vld_d;
            pkt_q        <= pkt_d;
            overflow_q   <= drop | (overflow_q & ~clear_errors);
        end
    end

endmodule

// File: tb/tb_scard_rx_ctrl.sv
// Self-checking bench for scard_rx_ctrl: directed scenarios plus randomized traffic vs a queue model.
module tb_scard_rx_ctrl;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        rx_data_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_endofpacket = 1'b0;
    logic [23:0] timeout_cycles = 24'd0;
    logic        clear_errors = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic [4:0]  fifo_level;
    logic [7:0]  pkt_bytes;
    logic        overflow;
    logic        timeout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO as a queue of {last,data}, packet bookkeeping as plain variables.
    logic [8:0] mq [$];
    bit         m_active, m_inpkt, m_ovf, m_to, m_drop;
    logic [7:0] m_stage;
    int         m_pkt, m_cnt;

    scard_rx_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .rx_data_ready  (rx_data_ready),
        .rx_data        (rx_data),
        .rx_endofpacket (rx_endofpacket),
        .timeout_cycles (timeout_cycles),
        .clear_errors   (clear_errors),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_level     (fifo_level),
        .pkt_bytes      (pkt_bytes),
        .overflow       (overflow),
        .timeout        (timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    function automatic void model_reset();
        mq.delete();
        m_active = 0; m_inpkt = 0; m_ovf = 0; m_to = 0; m_drop = 0;
        m_stage = 8'h00; m_pkt = 0; m_cnt = 0;
    endfunction

    function automatic void m_push(input logic [8:0] e);
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_drop = 1;
    endfunction

    // One clock of the model, using the inputs the DUT sampled at this edge.
    function automatic void model_step();
        bit exp_now = 0;
        int cnt_next;
        m_drop = 0;
        if (mq.size() != 0 && out_ready) mq.delete(0);
`ifdef SCARD_RX_TIMEOUT_EN
        exp_now = m_active && enable && !rx_data_ready && (timeout_cycles != 0) &&
                  (m_cnt == int'(timeout_cycles));
`endif
        cnt_next = (!m_active || !enable || rx_data_ready || exp_now) ? 0 : m_cnt + 1;
        if (!m_active) begin
            if (enable) m_active = 1;
        end else if (!enable) begin
            if (m_inpkt) m_push({1'b1, m_stage});
            m_inpkt = 0;
            m_active = 0;
        end else if (rx_data_ready) begin
            if (!m_inpkt) begin
                m_pkt = 1;
                if (rx_endofpacket) m_push({1'b1, rx_data});
                else begin m_stage = rx_data; m_inpkt = 1; end
            end else begin
                m_push({1'b0, m_stage});
                m_pkt = (m_pkt < 255) ? m_pkt + 1 : 255;
                if (rx_endofpacket) begin m_push({1'b1, rx_data}); m_inpkt = 0; end
                else m_stage = rx_data;
            end
        end else if ((rx_endofpacket || exp_now) && m_inpkt) begin
            m_push({1'b1, m_stage});
            m_inpkt = 0;
        end
        m_cnt = cnt_next;
        m_ovf = m_drop | (m_ovf & !clear_errors);
        m_to  = exp_now | (m_to & !clear_errors);
    endfunction

    function automatic logic [25:0] exp_vec();
        logic [8:0] h = (mq.size() != 0) ? mq[0] : 9'd0;
        return {mq.size() != 0, h, 5'(mq.size()), 8'(m_pkt), m_ovf, m_to, m_inpkt};
    endfunction

    function automatic logic [25:0] obs_vec();
        return {out_valid, out_valid ? {out_last, out_data} : 9'd0, fifo_level, pkt_bytes,
                overflow, timeout, busy};
    endfunction

    task automatic tick(input bit en, input bit rdy, input logic [7:0] d, input bit eop,
                        input bit ordy, input bit clr);
        enable = en; rx_data_ready = rdy; rx_data = d; rx_endofpacket = eop;
        out_ready = ordy; clear_errors = clr;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00, 1'b0, ordy, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({out_valid, out_last, out_data, fifo_level, pkt_bytes, overflow, timeout, busy} !== '0)
        begin
            errors++;
            $display("FAIL reset_values: got %h want 0", {out_valid, out_last, out_data,
                     fifo_level, pkt_bytes, overflow, timeout, busy});
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL after_reset_enable: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        logic [8:0] want [3] = '{9'h03B, 9'h095, 9'h113};
        send(8'h3B); send(8'h95); send(8'h13);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (pkt_bytes !== 8'd3) begin
            errors++; $display("FAIL basic_pkt_bytes: got %0d want 3", pkt_bytes);
        end
        checks++;
        if (fifo_level !== 5'd3 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_level: got %0d busy %b want 3 busy 0", fifo_level, busy);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || {out_last, out_data} !== want[i]) begin
                errors++;
                $display("FAIL basic_read%0d: got %b/%h want %h", i, out_valid,
                         {out_last, out_data}, want[i]);
            end
            idle(1, 1'b1);
        end
        checks++;
        if (fifo_level !== 5'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_empty: got level %0d valid %b", fifo_level, out_valid);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) send(8'h40 + 8'(i));
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: got level %0d ovf %b want 16 1", fifo_level, overflow);
        end
        checks++;
        if ({out_last, out_data} !== 9'h040) begin
            errors++; $display("FAIL ovf_head: got %h want 040", {out_last, out_data});
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({out_last, out_data} !== {1'b0, 8'h40 + 8'(i)}) begin
                errors++;
                $display("FAIL ovf_drain%0d: got %h want %h", i, {out_last, out_data},
                         {1'b0, 8'h40 + 8'(i)});
            end
            idle(1, 1'b1);
        end
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_after_drain: got valid %b ovf %b", out_valid, overflow);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            tick(1'b1, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
            if (i == 253) begin
                checks++;
                if (pkt_bytes !== 8'd254) begin
                    errors++; $display("FAIL sat_254: got %0d want 254", pkt_bytes);
                end
            end
        end
        checks++;
        if (pkt_bytes !== 8'd255 || overflow !== 1'b0) begin
            errors++; $display("FAIL sat_255: got %0d ovf %b want 255 0", pkt_bytes, overflow);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || out_valid !== 1'b0) begin
            errors++; $display("FAIL sat_end: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_same_cycle();
        tick(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_last, out_data} !== 10'h3A5 || busy !== 1'b0 || fifo_level !== 5'd1)
        begin
            errors++;
            $display("FAIL same_wait: got %b/%h busy %b want 1a5 busy 0", out_valid,
                     {out_last, out_data}, busy);
        end
        send(8'h11);
        tick(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 5'd3 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL same_recv: got %h want %h", obs_vec(), exp_vec());
        end
        idle(1, 1'b1);
        idle(1, 1'b1);
        checks++;
        if ({out_last, out_data} !== 9'h122) begin
            errors++; $display("FAIL same_recv_tail: got %h want 122", {out_last, out_data});
        end
        idle(1, 1'b1);
    endtask

    task automatic test_watchdog();
        timeout_cycles = 24'd100;
        send(8'h42);
`ifdef SCARD_RX_TIMEOUT_EN
        idle(100, 1'b0);
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL wd_early: got to %b busy %b want 0 1", timeout, busy);
        end
        idle(1, 1'b0);
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0 || {out_valid, out_last, out_data} !== 10'h342)
        begin
            errors++;
            $display("FAIL wd_expire: got to %b busy %b head %b/%h want 1 0 142", timeout, busy,
                     out_valid, {out_last, out_data});
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        checks++;
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL wd_clear: got %b want 0", timeout);
        end
`else
        idle(150, 1'b0);
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wd_disabled: got to %b busy %b valid %b", timeout, busy, out_valid);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_last, out_data} !== 10'h342) begin
            errors++; $display("FAIL wd_disabled_eop: got %h want 342",
                               {out_valid, out_last, out_data});
        end
        idle(1, 1'b1);
`endif
        timeout_cycles = 24'd0;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL wd_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_disable();
        send(8'h01); send(8'h02);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 5'd2 || busy !== 1'b0 || {out_last, out_data} !== 9'h001) begin
            errors++;
            $display("FAIL dis_flush: got level %0d busy %b head %h want 2 0 001", fifo_level,
                     busy, {out_last, out_data});
        end
        tick(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 5'd2 || busy !== 1'b0) begin
            errors++; $display("FAIL dis_ignore: got level %0d busy %b want 2 0", fifo_level, busy);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_last, out_data} !== 10'h302) begin
            errors++; $display("FAIL dis_tail: got %h want 302", {out_valid, out_last, out_data});
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || out_valid !== 1'b0) begin
            errors++; $display("FAIL dis_model: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int rdy_pct, ordy_pct;
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: begin rdy_pct = 40; ordy_pct = 60; end
                1: begin rdy_pct = 8;  ordy_pct = 50; end
                2: begin rdy_pct = 80; ordy_pct = 20; end
                default: begin rdy_pct = 20; ordy_pct = 80; end
            endcase
            timeout_cycles = (p % 2 == 1) ? 24'($urandom_range(3, 12)) : 24'd0;
            for (int i = 0; i < 700; i++) begin
                tick($urandom_range(0, 49) != 0, $urandom_range(0, 99) < rdy_pct, 8'($urandom),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 99) < ordy_pct,
                     $urandom_range(0, 29) == 0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL rand_p%0d_c%0d: got %h want %h", p, i, obs_vec(), exp_vec());
                end
            end
        end
        timeout_cycles = 24'd0;
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 40 && mq.size() != 0; i++) idle(1, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rand_settle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i));
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (fifo_level !== 5'd5) begin
            errors++; $display("FAIL arst_fill: got %0d want 5", fifo_level);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_data, fifo_level, pkt_bytes, overflow, timeout, busy} !== '0)
        begin
            errors++;
            $display("FAIL arst_immediate: got %h want 0", {out_valid, out_last, out_data,
                     fifo_level, pkt_bytes, overflow, timeout, busy});
        end
        model_reset();
        enable = 1'b0; rx_data_ready = 1'b0; rx_endofpacket = 1'b0; out_ready = 1'b0;
        #20;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL arst_release%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_saturate();
        test_same_cycle();
        test_watchdog();
        test_disable();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
